// File: rtl/clk_div_nch.sv
// Multi-channel programmable clock/strobe divider: per-channel counter with
// double-buffered divisor, toggle or pulse output, wrap tick and global phase sync.
module clk_div_nch #(
  parameter int N       = 8,
  parameter int CH      = 2,
  parameter int DEF_DIV = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [CH-1:0] i_en,
  input  logic [CH-1:0] i_mode,
  input  logic [N-1:0]  i_div_in,
  input  logic [CH-1:0] i_div_wr,
  input  logic          i_sync,
  output logic [CH-1:0] o_div_out,
  output logic [CH-1:0] o_tick,
  output logic [CH-1:0] o_pend
);

  localparam logic [N-1:0] LP_DEF_DIV = N'(DEF_DIV);
  localparam logic [N-1:0] LP_ONE     = N'(1);

  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic [N-1:0] r_count;
    logic [N-1:0] r_div;
    logic [N-1:0] r_pdiv;
    logic         r_pend;
    logic         r_out;
    logic         r_tick;
    logic         w_run;
    logic         w_wrap;

    // A zero divisor stalls the channel; only a running channel can wrap.
    assign w_run  = i_en[g] && (r_div != '0);
    assign w_wrap = w_run && (r_count == r_div - LP_ONE);

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_count <= '0;
        r_div   <= LP_DEF_DIV;
        r_pdiv  <= '0;
        r_pend  <= 1'b0;
        r_out   <= 1'b0;
        r_tick  <= 1'b0;
      end else begin
        // NOTE: non-blocking assignments let later statements in this block
        // override earlier defaults; the last one reached on an edge wins.
        r_tick <= 1'b0;
        if (i_sync) begin
          r_count <= '0;
          r_out   <= 1'b0;
          if (r_pend) begin
            r_div  <= r_pdiv;
            r_pend <= 1'b0;
          end
        end else if (!w_run) begin
          if (r_pend) begin
            r_div  <= r_pdiv;
            r_pend <= 1'b0;
            if (!i_en[g]) r_count <= '0;
          end
        end else if (w_wrap) begin
          r_count <= '0;
          r_tick  <= 1'b1;
          r_out   <= i_mode[g] ? 1'b1 : ~r_out;
          if (r_pend) begin
            r_div  <= r_pdiv;
            r_pend <= 1'b0;
          end
        end else begin
          r_count <= r_count + LP_ONE;
          if (i_mode[g]) r_out <= 1'b0;
        end
        // A write always lands last so it survives a same-edge apply.
        if (i_div_wr[g]) begin
          r_pdiv <= i_div_in;
          r_pend <= 1'b1;
        end
      end
    end

    assign o_div_out[g] = r_out;
    assign o_tick[g]    = r_tick;
    assign o_pend[g]    = r_pend;
  end

endmodule
